// File: rtl/sram_arb.sv
// sram_arb: arbitrates three requesters (W capture, R readout, C compare) onto one async SRAM.
// Optional macro SRAM_ARB_WAIT_EN stretches the access strobe by WAIT_CYC extra cycles.
module sram_arb #(
    parameter int WAIT_CYC = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        W_REQ,
    input  logic [19:0] W_ADR,
    input  logic [15:0] W_DAT,
    output logic        W_ACK,
    input  logic        R_REQ,
    input  logic [19:0] R_ADR,
    output logic        R_ACK,
    input  logic        C_REQ,
    input  logic [19:0] C_ADR,
    output logic        C_ACK,
    output logic [15:0] RDATA,
    output logic [19:0] SRAM_ADR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic [1:0]  GNT,
    output logic [1:0]  o_dbg_state
);
    // Handshake: a requester raises *_REQ with address/data stable and holds it until its
    // *_ACK pulse (one cycle, the IDLE cycle after END); a REQ still high at that cycle's
    // closing edge is taken as a new request.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADR = 2'd1, S_ACC = 2'd2, S_END = 2'd3} state_t;

    localparam logic [1:0] ID_W = 2'd1;
    localparam logic [1:0] ID_R = 2'd2;
    localparam logic [1:0] ID_C = 2'd3;

    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_wait_range
        $error("sram_arb: WAIT_CYC must be 1..15");
    end

    state_t      r_state;
    logic [1:0]  r_gnt;
    logic        r_rr_c;
    logic [19:0] r_adr;
    logic [15:0] r_wdat;
    logic [15:0] r_rdata;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_dq_oe;
    logic        r_w_ack;
    logic        r_r_ack;
    logic        r_c_ack;
    logic [1:0]  w_pick;
`ifdef SRAM_ARB_WAIT_EN
    logic [3:0]  r_wait;
`endif

    // W has absolute priority; r_rr_c selects C when R and C collide.
    always_comb begin
        w_pick = 2'd0;
        if (W_REQ)                 w_pick = ID_W;
        else if (R_REQ && C_REQ)   w_pick = r_rr_c ? ID_C : ID_R;
        else if (R_REQ)            w_pick = ID_R;
        else if (C_REQ)            w_pick = ID_C;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_gnt   <= 2'd0;
            r_rr_c  <= 1'b0;
            r_adr   <= 20'd0;
            r_wdat  <= 16'd0;
            r_rdata <= 16'd0;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_w_ack <= 1'b0;
            r_r_ack <= 1'b0;
            r_c_ack <= 1'b0;
`ifdef SRAM_ARB_WAIT_EN
            r_wait  <= 4'd0;
`endif
        end else begin
            r_w_ack <= 1'b0;
            r_r_ack <= 1'b0;
            r_c_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick != 2'd0) begin
                        r_state <= S_ADR;
                        r_gnt   <= w_pick;
                        r_dq_oe <= (w_pick == ID_W);
                        case (w_pick)
                            ID_W:    r_adr <= W_ADR;
                            ID_R:    r_adr <= R_ADR;
                            default: r_adr <= C_ADR;
                        endcase
                        if (w_pick == ID_W) r_wdat <= W_DAT;
                        else                r_rr_c <= (w_pick == ID_R);
                    end
                end
                S_ADR: begin
                    r_state <= S_ACC;
                    if (r_gnt == ID_W) r_we_n <= 1'b0;
                    else               r_oe_n <= 1'b0;
`ifdef SRAM_ARB_WAIT_EN
                    r_wait  <= 4'(WAIT_CYC);
`endif
                end
                S_ACC: begin
`ifdef SRAM_ARB_WAIT_EN
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end else begin
                        r_state <= S_END;
                        r_we_n  <= 1'b1;
                    end
`else
                    r_state <= S_END;
                    r_we_n  <= 1'b1;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'd0;
                    r_oe_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    if (r_gnt != ID_W) r_rdata <= SRAM_DQ;
                    r_w_ack <= (r_gnt == ID_W);
                    r_r_ack <= (r_gnt == ID_R);
                    r_c_ack <= (r_gnt == ID_C);
                end
            endcase
        end
    end

    assign SRAM_DQ     = r_dq_oe ? r_wdat : 16'hzzzz;
    assign SRAM_ADR    = r_adr;
    assign SRAM_OE_N   = r_oe_n;
    assign SRAM_WE_N   = r_we_n;
    assign RDATA       = r_rdata;
    assign GNT         = r_gnt;
    assign W_ACK       = r_w_ack;
    assign R_ACK       = r_r_ack;
    assign C_ACK       = r_c_ack;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: random and directed request rounds against a priority/round-robin reference model.
`timescale 1ns/1ps
module tb_sram_arb;
  localparam int WAIT_CYC = 3;
`ifdef SRAM_ARB_WAIT_EN
  localparam int WAITS = WAIT_CYC;
`else
  localparam int WAITS = 0;
`endif
  localparam int PERIOD = 4 + WAITS;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        W_REQ = 1'b0, R_REQ = 1'b0, C_REQ = 1'b0;
  logic [19:0] W_ADR = '0, R_ADR = '0, C_ADR = '0;
  logic [15:0] W_DAT = '0;
  logic        W_ACK, R_ACK, C_ACK;
  logic [15:0] RDATA;
  logic [19:0] SRAM_ADR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_OE_N, SRAM_WE_N;
  logic [1:0]  GNT;
  logic [1:0]  o_dbg_state;

  sram_arb #(.WAIT_CYC(WAIT_CYC)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .W_REQ(W_REQ), .W_ADR(W_ADR), .W_DAT(W_DAT), .W_ACK(W_ACK),
    .R_REQ(R_REQ), .R_ADR(R_ADR), .R_ACK(R_ACK),
    .C_REQ(C_REQ), .C_ADR(C_ADR), .C_ACK(C_ACK),
    .RDATA(RDATA), .SRAM_ADR(SRAM_ADR), .SRAM_DQ(SRAM_DQ),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .GNT(GNT),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [1:0]  port;
    logic [19:0] adr;
    logic [15:0] dat;
    logic [31:0] cyc;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic rr_next_c = 1'b0;
  int we_len = 0;
  int oe_len = 0;
  logic [19:0] we_adr = '0;
  logic [15:0] we_dat = '0;
  logic [1:0]  last_gnt = '0;
  logic [15:0] ref_mem [logic [19:0]];

  function automatic logic [15:0] dflt(input logic [19:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ref_read(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ---------------- external SRAM model ----------------
  logic [15:0] sram_mem [logic [19:0]];
  logic [15:0] sram_rd = '0;
  assign SRAM_DQ = (!SRAM_OE_N) ? sram_rd : 16'hzzzz;
  initial forever begin
    @(negedge CLK);
    sram_rd = sram_mem.exists(SRAM_ADR) ? sram_mem[SRAM_ADR] : dflt(SRAM_ADR);
  end
  initial forever begin
    @(posedge SRAM_WE_N);
    if (RSTN) sram_mem[SRAM_ADR] = SRAM_DQ;
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    logic [1:0] p;
    forever begin
      @(negedge CLK);
      if (RSTN) begin
        check("strobe_overlap", 32'(!SRAM_WE_N && !SRAM_OE_N), 0);
        if (!SRAM_WE_N) begin we_len++; we_adr = SRAM_ADR; we_dat = SRAM_DQ; end
        if (!SRAM_OE_N) oe_len++;
        if (GNT != 2'd0) last_gnt = GNT;
        if (W_ACK || R_ACK || C_ACK) begin
          p = W_ACK ? 2'd1 : (R_ACK ? 2'd2 : 2'd3);
          check("ack_onehot", 32'(W_ACK) + 32'(R_ACK) + 32'(C_ACK), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: port %0d at cycle %0d, none expected", p, cyc);
          end else begin
            e = exp_q.pop_front();
            check("ack_port", 32'(p), 32'(e.port));
            check("ack_cycle", cyc, e.cyc);
            check("gnt_idle_on_ack", 32'(GNT), 0);
            check("owner_gnt", 32'(last_gnt), 32'(e.port));
            if (e.port == 2'd1) begin
              check("we_adr", 32'(we_adr), 32'(e.adr));
              check("we_dat", 32'(we_dat), 32'(e.dat));
              check("we_len", we_len, 1 + WAITS);
              check("oe_in_write", oe_len, 0);
            end else begin
              check("rdata", 32'(RDATA), 32'(e.dat));
              check("oe_len", oe_len, 2 + WAITS);
              check("we_in_read", we_len, 0);
            end
          end
          we_len = 0;
          oe_len = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RSTN = 1'b0;
    W_REQ = 1'b0; R_REQ = 1'b0; C_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    exp_q.delete();
    rr_next_c = 1'b0;
    we_len = 0;
    oe_len = 0;
    RSTN = 1'b1;
  endtask

  // Issue nw/nr/nc accesses; each requester holds REQ until its last ACK, then drops it.
  // The model serves W first, then R/C alternating from the pointer; accesses complete back-to-back.
  task automatic run_round(input int nw, input int nr, input int nc,
                           input logic [19:0] wa, input logic [15:0] wd,
                           input logic [19:0] ra, input logic [19:0] ca, input bit withdraw);
    int rem[4];
    int t;
    int p;
    int budget;
    logic [19:0] a;
    exp_t e;
    check("idle_gnt", 32'(GNT), 0);
    rem[0] = 0; rem[1] = nw; rem[2] = nr; rem[3] = nc;
    t = cyc + PERIOD;
    while (rem[1] + rem[2] + rem[3] > 0) begin
      if (rem[1] > 0)                   p = 1;
      else if (rem[2] > 0 && rem[3] > 0) p = rr_next_c ? 3 : 2;
      else if (rem[2] > 0)              p = 2;
      else                              p = 3;
      if (p != 1) rr_next_c = (p == 2);
      rem[p]--;
      e.port = 2'(p);
      e.cyc  = 32'(t);
      if (p == 1) begin
        ref_mem[wa] = wd;
        e.adr = wa;
        e.dat = wd;
      end else begin
        a = (p == 2) ? ra : ca;
        e.adr = a;
        e.dat = ref_read(a);
      end
      exp_q.push_back(e);
      t += PERIOD;
    end
    W_ADR = wa; W_DAT = wd; R_ADR = ra; C_ADR = ca;
    W_REQ = (nw > 0); R_REQ = (nr > 0); C_REQ = (nc > 0);
    rem[1] = nw; rem[2] = nr; rem[3] = nc;
    budget = (nw + nr + nc) * PERIOD + 8;
    if (withdraw) begin
      @(negedge CLK);
      budget--;
      W_REQ = 1'b0; R_REQ = 1'b0; C_REQ = 1'b0;
    end
    while (rem[1] + rem[2] + rem[3] > 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
      if (W_ACK && rem[1] > 0) begin rem[1]--; if (rem[1] == 0) W_REQ = 1'b0; end
      if (R_ACK && rem[2] > 0) begin rem[2]--; if (rem[2] == 0) R_REQ = 1'b0; end
      if (C_ACK && rem[3] > 0) begin rem[3]--; if (rem[3] == 0) C_REQ = 1'b0; end
    end
    if (rem[1] + rem[2] + rem[3] > 0) begin
      checks++;
      errors++;
      $display("FAIL round_timeout: %0d acks outstanding at cycle %0d", rem[1] + rem[2] + rem[3], cyc);
      W_REQ = 1'b0; R_REQ = 1'b0; C_REQ = 1'b0;
      exp_q.delete();
    end
    @(negedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [19:0] pool [8];

  initial begin
    int budget;
    int nw, nr, nc;
    repeat (3) @(negedge CLK);
    check("rst_gnt", 32'(GNT), 0);
    check("rst_w_ack", 32'(W_ACK), 0);
    check("rst_r_ack", 32'(R_ACK), 0);
    check("rst_c_ack", 32'(C_ACK), 0);
    check("rst_oe_n", 32'(SRAM_OE_N), 1);
    check("rst_we_n", 32'(SRAM_WE_N), 1);
    check("rst_sram_adr", 32'(SRAM_ADR), 0);
    check("rst_rdata", 32'(RDATA), 0);
    check("rst_state", 32'(o_dbg_state), 0);
    RSTN = 1'b1;
    @(negedge CLK);

    run_round(1, 0, 0, 20'h40000, 16'h00C8, 20'h0, 20'h0, 1'b0);
    run_round(1, 0, 0, 20'h00010, 16'h0096, 20'h0, 20'h0, 1'b0);
    run_round(0, 1, 0, 20'h0, 16'h0, 20'h00010, 20'h0, 1'b0);

    do_reset();
    @(negedge CLK);
    run_round(1, 1, 1, 20'h00020, 16'hBEEF, 20'h00010, 20'h40000, 1'b0);
    run_round(0, 3, 3, 20'h0, 16'h0, 20'h00020, 20'h00010, 1'b0);
    run_round(3, 1, 1, 20'h00030, 16'h1111, 20'h00030, 20'h00020, 1'b0);
    run_round(0, 0, 1, 20'h0, 16'h0, 20'h0, 20'h00030, 1'b1);

    // Reset during the write strobe: abort without ACK, then the held W_REQ is served again.
    W_ADR = 20'h0ABCD; W_DAT = 16'h1357; W_REQ = 1'b1;
    budget = 20;
    while (SRAM_WE_N && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    check("we_reached", 32'(SRAM_WE_N), 0);
    #2 RSTN = 1'b0;
    #1;
    check("abort_we_n", 32'(SRAM_WE_N), 1);
    check("abort_gnt", 32'(GNT), 0);
    check("abort_w_ack", 32'(W_ACK), 0);
    check("abort_state", 32'(o_dbg_state), 0);
    check("abort_sram_adr", 32'(SRAM_ADR), 0);
    check("abort_rdata", 32'(RDATA), 0);
    repeat (2) @(negedge CLK);
    exp_q.delete();
    rr_next_c = 1'b0;
    we_len = 0;
    oe_len = 0;
    RSTN = 1'b1;
    run_round(1, 0, 0, 20'h0ABCD, 16'h1357, 20'h0, 20'h0, 1'b0);

    for (int i = 0; i < 8; i++) pool[i] = 20'($urandom);
    for (int r = 0; r < 25; r++) begin
      nw = $urandom_range(0, 2);
      nr = $urandom_range(0, 2);
      nc = $urandom_range(0, 2);
      if (nw + nr + nc == 0) nr = 1;
      run_round(nw, nr, nc, pool[$urandom_range(0, 7)], 16'($urandom),
                pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)], 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 2, number of extra access-strobe cycles (1..15); used only when SRAM_ARB_WAIT_EN is defined.
REQ-002 SHALL have port CLK  input  1  single clock for all logic, rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port W_REQ  input  1  waveform-capture write request, held until W_ACK.
REQ-005 SHALL have port W_ADR  input  20  write address, stable while W_REQ=1.
REQ-006 SHALL have port W_DAT  input  16  write data, stable while W_REQ=1.
REQ-007 SHALL have port W_ACK  output  1  one-cycle pulse: write complete.
REQ-008 SHALL have port R_REQ  input  1  USB readout read request, held until R_ACK.
REQ-009 SHALL have port R_ADR  input  20  readout address.
REQ-010 SHALL have port R_ACK  output  1  one-cycle pulse: RDATA valid for readout.
REQ-011 SHALL have port C_REQ  input  1  reference-compare read request, held until C_ACK.
REQ-012 SHALL have port C_ADR  input  20  compare address.
REQ-013 SHALL have port C_ACK  output  1  one-cycle pulse: RDATA valid for compare.
REQ-014 SHALL have port RDATA  output  16  last read word, held until next read completes.
REQ-015 SHALL have port SRAM_ADR  output  20  SRAM address bus.
REQ-016 SHALL have port SRAM_DQ  inout  16  SRAM data bus.
REQ-017 SHALL have port SRAM_OE_N  output  1  SRAM output enable, active-low.
REQ-018 SHALL have port SRAM_WE_N  output  1  SRAM write enable, active-low.
REQ-019 SHALL have port GNT  output  2  current owner: 0 none, 1 W, 2 R, 3 C.

Function
REQ-020 SHALL implement states IDLE, ADR, ACC, END; every access runs IDLE->ADR->ACC->END->IDLE, no skipping.
REQ-021 In IDLE, SHALL grant on the clock edge where any request is high; priority W over R and C; R vs C round-robin, starting with R after reset, toggling only after an R or C grant.
REQ-022 On grant SHALL latch address (and W_DAT for writes) and GNT; later changes on requester inputs during the access SHALL be ignored.
REQ-023 ADR: SRAM_ADR driven, OE_N=1, WE_N=1; for writes SRAM_DQ driven with latched data from ADR through END.
REQ-024 ACC: writes WE_N=0; reads OE_N=0; SRAM_DQ high-Z for reads; ACC lasts exactly 1 cycle without SRAM_ARB_WAIT_EN.
REQ-025 END: WE_N=1, OE_N held 0 for reads; RDATA captures SRAM_DQ at the edge leaving END; matching ACK asserts the cycle after END (IDLE cycle) for exactly one cycle.
REQ-026 Latency: request high at edge N (in IDLE) -> ACK high during cycle N+4; throughput one access per 4 cycles (4+WAIT_CYC with macro).
REQ-027 New grant SHALL be permitted in the same IDLE cycle that ACK is high; requester deasserting REQ on ACK SHALL not be re-granted.
REQ-028 Simultaneous W, R, C in IDLE: order W, then R/C per round-robin pointer; W continuously high SHALL starve R/C (by design).
REQ-029 Request withdrawn mid-access: access completes and ACK still pulses.
REQ-030 WE_N and OE_N SHALL never be low together; SRAM_DQ SHALL never be driven while OE_N=0.
REQ-031 GNT SHALL read 0 in IDLE and the owner ID in ADR/ACC/END.

Reset
REQ-032 RSTN low SHALL immediately force IDLE, GNT=0, W_ACK=R_ACK=C_ACK=0, OE_N=1, WE_N=1, SRAM_DQ high-Z, SRAM_ADR=0, RDATA=0, round-robin pointer=R.
REQ-033 Reset mid-access SHALL abort without ACK; first grant follows the first edge with RSTN high.

Configuration
REQ-034 With SRAM_ARB_WAIT_EN defined, ACC SHALL last 1+WAIT_CYC cycles via an internal wait counter; ACK latency becomes 4+WAIT_CYC.
REQ-035 Without SRAM_ARB_WAIT_EN, no wait counter exists and WAIT_CYC is ignored.

Verification
REQ-036 W_REQ, W_ADR=0x40000, W_DAT=0x00C8 -> WE_N low one cycle with SRAM_ADR=0x40000, DQ=0x00C8; W_ACK at N+4.
REQ-037 Write 0x0096 to 0x00010, then R_REQ R_ADR=0x00010 -> R_ACK at N+4, RDATA=0x0096.
REQ-038 W, R, C all high same edge, held -> grant order W, R, C; ACKs in cycles N+4, N+8, N+12.
REQ-039 R and C continuously high -> GNT alternates 2,3,2,3; no C starvation.
REQ-040 RSTN low during ACC of a write -> WE_N=1 same cycle, no W_ACK; after release, pending W_REQ re-granted.
REQ-041 SRAM_ARB_WAIT_EN, WAIT_CYC=3 -> OE_N low 5 cycles (ACC 4 + END 1), R_ACK at N+7.
